// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART-driven program loader that writes a framed program into CPU RAM
//
// Receives 8N1 bytes on uart_rx and turns a frame of the form
//   0xA5, LEN, DATA[0..LEN-1], CHK   (CHK = sum of DATA mod 256)
// into address/data bus cycles: for every data byte one MAR-load cycle with
// the address on the bus, then one RAM-write cycle with the data on the bus.
// The CPU clock is held halted while a frame is in progress.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   uart_rx    in   serial input, idle high, asynchronous to clk
//   load_en    in   programming-mode switch; low = loader ignores the line
//   bus_out    out  value driven toward the CPU bus
//   bus_drive  out  loader owns the bus this cycle
//   mar_load   out  MAR captures the bus this cycle
//   ram_write  out  RAM writes the bus at MAR this cycle
//   cpu_halt   out  halt request to the clock block
//   busy       out  frame in progress
//   frame_err  out  sticky: bad stop bit, bad length or abort
//   chk_err    out  sticky: checksum mismatch on the last frame

module uart_program_loader #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115_200,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    input  logic                  load_en,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_drive,
    output logic                  mar_load,
    output logic                  ram_write,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  chk_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int LEN_W        = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [8:0]       MAX_LEN  = 9'(2 ** ADDR_WIDTH);
    localparam logic [7:0]       SYNC     = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_RX_DATA, S_WR_ADDR, S_WR_DATA, S_CHECK} state_t;

    // ---------------------------------------------------------------- RX
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             stop_err_q, stop_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Edge rather than level, so a line still low after a bad
                // stop bit is not mistaken for a new start bit.
                if (rx_s3_q && !rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_BITS: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                    else               bit_d      = bit_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    byte_valid_d = rx_s2_q;
                    stop_err_d   = !rx_s2_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- frame FSM
    state_t                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [7:0]            sum_q, sum_d;
    logic [DATA_WIDTH-1:0] bus_out_q, bus_out_d;
    logic                  bus_drive_q, bus_drive_d;
    logic                  mar_load_q, mar_load_d;
    logic                  ram_write_q, ram_write_d;
    logic                  cpu_halt_q, cpu_halt_d;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic                  chk_err_q, chk_err_d;
    logic [LEN_W-1:0]      addr_inc;

    assign addr_inc = addr_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sum_d       = sum_q;
        frame_err_d = frame_err_q;
        chk_err_d   = chk_err_q;

        if (state_q != S_IDLE && !load_en) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
        end else if (stop_err_q) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (byte_valid_q && shift_q == SYNC && load_en) begin
                        frame_err_d = 1'b0;
                        chk_err_d   = 1'b0;
                        sum_d       = '0;
                        state_d     = S_LEN;
                    end
                end
                S_LEN: begin
                    if (byte_valid_q) begin
                        if (shift_q == 8'd0 || {1'b0, shift_q} > MAX_LEN) begin
                            frame_err_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            len_d   = LEN_W'(shift_q);
                            addr_d  = '0;
                            state_d = S_RX_DATA;
                        end
                    end
                end
                S_RX_DATA: begin
                    if (byte_valid_q) begin
                        data_d  = DATA_WIDTH'(shift_q);
                        sum_d   = sum_q + shift_q;
                        state_d = S_WR_ADDR;
                    end
                end
                S_WR_ADDR: state_d = S_WR_DATA;
                S_WR_DATA: begin
                    addr_d  = addr_inc;
                    state_d = (addr_inc == len_q) ? S_CHECK : S_RX_DATA;
                end
                S_CHECK: begin
                    if (byte_valid_q) begin
                        if (shift_q != sum_q) chk_err_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they are registered
        // and line up exactly with the state they belong to.
        mar_load_d  = (state_d == S_WR_ADDR);
        ram_write_d = (state_d == S_WR_DATA);
        bus_drive_d = mar_load_d || ram_write_d;
        cpu_halt_d  = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        if (mar_load_d)       bus_out_d = DATA_WIDTH'(addr_q[ADDR_WIDTH-1:0]);
        else if (ram_write_d) bus_out_d = data_q;
        else                  bus_out_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_s3_q      <= 1'b1;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
            state_q      <= S_IDLE;
            len_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            sum_q        <= '0;
            bus_out_q    <= '0;
            bus_drive_q  <= 1'b0;
            mar_load_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            cpu_halt_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            chk_err_q    <= 1'b0;
        end else begin
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            rx_s3_q      <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
            state_q      <= state_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sum_q        <= sum_d;
            bus_out_q    <= bus_out_d;
            bus_drive_q  <= bus_drive_d;
            mar_load_q   <= mar_load_d;
            ram_write_q  <= ram_write_d;
            cpu_halt_q   <= cpu_halt_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            chk_err_q    <= chk_err_d;
        end
    end

    assign bus_out   = bus_out_q;
    assign bus_drive = bus_drive_q;
    assign mar_load  = mar_load_q;
    assign ram_write = ram_write_q;
    assign cpu_halt  = cpu_halt_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign chk_err   = chk_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - directed self-checking bench for uart_program_loader

module tb_uart_program_loader;

    localparam int CPB = 64;

    logic       clk;
    logic       rst_n;
    logic       uart_rx;
    logic       load_en;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic       mar_load;
    logic       ram_write;
    logic       cpu_halt;
    logic       busy;
    logic       frame_err;
    logic       chk_err;

    uart_program_loader #(
        .CLK_FREQ  (6_400_000),
        .BAUD      (100_000),
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .load_en  (load_en),
        .bus_out  (bus_out),
        .bus_drive(bus_drive),
        .mar_load (mar_load),
        .ram_write(ram_write),
        .cpu_halt (cpu_halt),
        .busy     (busy),
        .frame_err(frame_err),
        .chk_err  (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus monitor: logs every strobe and counts protocol violations.
    int         mar_cnt = 0;
    int         wr_cnt = 0;
    int         overlap_cnt = 0;
    int         drive_bad = 0;
    int         dbl_cnt = 0;
    logic       prev_mar = 1'b0;
    logic       prev_wr = 1'b0;
    logic [7:0] mar_hist [0:255];
    logic [7:0] wr_hist  [0:255];
    logic [7:0] exp_data [0:15];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mar = 1'b0;
            prev_wr  = 1'b0;
        end else begin
            if (mar_load) begin
                mar_hist[mar_cnt[7:0]] = bus_out;
                mar_cnt = mar_cnt + 1;
            end
            if (ram_write) begin
                wr_hist[wr_cnt[7:0]] = bus_out;
                wr_cnt = wr_cnt + 1;
            end
            if (mar_load && ram_write) overlap_cnt = overlap_cnt + 1;
            if (bus_drive != (mar_load || ram_write)) drive_bad = drive_bad + 1;
            if ((mar_load && prev_mar) || (ram_write && prev_wr)) dbl_cnt = dbl_cnt + 1;
            prev_mar = mar_load;
            prev_wr  = ram_write;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({bus_out, bus_drive, mar_load, ram_write, cpu_halt, busy, frame_err, chk_err});
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic check_writes(input string tag, input int bm, input int bw, input int n);
        check_eq({tag, "_mar_cnt"}, 32'(mar_cnt - bm), 32'(n));
        check_eq({tag, "_wr_cnt"},  32'(wr_cnt - bw),  32'(n));
        for (int k = 0; k < n; k++) begin
            check_eq({tag, "_addr"}, 32'(mar_hist[bm + k]), 32'(k));
            check_eq({tag, "_data"}, 32'(wr_hist[bw + k]),  32'(exp_data[k]));
        end
    endtask

    initial begin
        int   bm;
        int   bw;
        logic found;

        rst_n   = 1'b0;
        uart_rx = 1'b1;
        load_en = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_outs", out_vec(), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: normal three-byte frame
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        check_eq("t1_halt_busy", 32'({cpu_halt, busy}), 32'h3);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check_eq("t1_halt_before_chk", 32'(cpu_halt), 32'h1);
        send_byte(8'h66, 1'b1);
        check_eq("t1_flags_after", out_vec(), 32'h0);
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        check_writes("t1", bm, bw, 3);

        // 2: checksum mismatch keeps the writes
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hFF, 1'b1);
        check_eq("t2_chk_err", 32'(chk_err), 32'h1);
        check_eq("t2_frame_err", 32'(frame_err), 32'h0);
        check_eq("t2_busy", 32'(busy), 32'h0);
        exp_data[0] = 8'h01; exp_data[1] = 8'h02;
        check_writes("t2", bm, bw, 2);

        // 3: illegal lengths 0 and 17
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        check_eq("t3_flags_cleared", 32'({frame_err, chk_err}), 32'h0);
        send_byte(8'h00, 1'b1);
        check_eq("t3a_state", 32'({frame_err, cpu_halt, busy}), 32'h4);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        check_eq("t3b_state", 32'({frame_err, cpu_halt, busy}), 32'h4);
        check_writes("t3", bm, bw, 0);

        // 4: bad stop bit, then a good frame clears it
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        check_eq("t4_stop_err", 32'(frame_err), 32'h1);
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h7E, 1'b1);
        check_eq("t4_recovered", out_vec(), 32'h0);
        exp_data[0] = 8'h7E;
        check_writes("t4", bm, bw, 1);

        // maximum length 16: addresses 0..15, no wrap
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h10, 1'b1);
        for (int i = 0; i < 16; i++) begin
            exp_data[i] = 8'(i + 1);
            send_byte(8'(i + 1), 1'b1);
        end
        send_byte(8'h88, 1'b1);
        check_eq("tmax_flags", out_vec(), 32'h0);
        check_writes("tmax", bm, bw, 16);

        // 5: load_en dropped after the second data byte of LEN=4
        bm = mar_cnt; bw = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        check_eq("t5_busy_before", 32'(busy), 32'h1);
        @(negedge clk);
        load_en = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_abort", 32'({frame_err, cpu_halt, busy}), 32'h4);
        @(negedge clk);
        load_en = 1'b1;
        exp_data[0] = 8'h10; exp_data[1] = 8'h20;
        check_writes("t5", bm, bw, 2);

        // 6: reset asserted during WR_ADDR
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        found = 1'b0;
        fork
            send_byte(8'hAA, 1'b1);
            begin
                for (int i = 0; i < 2000 && !found; i++) begin
                    @(negedge clk);
                    if (mar_load) found = 1'b1;
                end
                check_eq("t6_saw_wr_addr", 32'(found), 32'h1);
                check_eq("t6_addr_on_bus", 32'(bus_out), 32'h0);
                rst_n = 1'b0;
                #1;
                check_eq("t6_async_reset", out_vec(), 32'h0);
            end
        join
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 20-clock glitch must not start a byte that would swallow the next frame
        bm = mar_cnt; bw = wr_cnt;
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        check_eq("t6_a5_after_glitch", 32'(busy), 32'h1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h33, 1'b1);
        check_eq("t6_flags", out_vec(), 32'h0);
        exp_data[0] = 8'h33;
        check_writes("t6", bm, bw, 1);

        check_eq("strobe_overlap", 32'(overlap_cnt), 32'h0);
        check_eq("bus_drive_match", 32'(drive_bad), 32'h0);
        check_eq("strobe_width", 32'(dbl_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
